tmr_irq_ctrl: RTL and testbench

Timer interrupt controller sitting directly downstream of `timer_counter_8bit`. It consumes the TMR_OVF / TMR_UDF flags and latches each rising edge into a write-1-to-clear pending register. It counts events per source and drives a single maskable `irq` line, in level or pulse mode, to the CPU. It is programmed over the same 8-bit APB slave interface used by the timer.

---
 rtl/tmr_irq_ctrl_if.sv | 26 ++
 rtl/tmr_irq_ctrl.sv | 118 +++++++++++
 tb/tb_tmr_irq_ctrl.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/tmr_irq_ctrl_if.sv
// APB slave bundle shared by the timer and its interrupt controller.
//   psel/penable/pwrite/paddr/pwdata : driven by the bus master
//   prdata/pready/pslverr            : driven by the slave
interface tmr_irq_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 3
);
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/tmr_irq_ctrl.sv
// Timer interrupt controller. Edge-detects the timer OVF/UDF flags, latches them in a
// write-1-to-clear pending register, counts events per source (saturating) and drives one
// registered, maskable irq line in level or pulse mode.
// Ports:
//   pclk    : system clock, rising edge
//   preset  : synchronous active-high reset
//   apb     : 8-bit APB slave (zero wait states, pslverr on addresses 5..7)
//   tmr_ovf : timer overflow flag (level)
//   tmr_udf : timer underflow flag (level)
//   irq     : registered interrupt request
// Register map: 0 ISR (W1C), 1 IER, 2 OVF_CNT, 3 UDF_CNT, 4 CTRL[0]=MODE (1 = pulse).
module tmr_irq_ctrl #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 3
) (
  input  logic                 pclk,
  input  logic                 preset,
  tmr_irq_ctrl_if.slave        apb,
  input  logic                 tmr_ovf,
  input  logic                 tmr_udf,
  output logic                 irq
);

  localparam logic [ADDR_WIDTH-1:0] AddrIsr  = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] AddrIer  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] AddrOcnt = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] AddrUcnt = ADDR_WIDTH'(3);
  localparam logic [ADDR_WIDTH-1:0] AddrCtrl = ADDR_WIDTH'(4);

  // Bit 0 = OVF, bit 1 = UDF throughout.
  logic       ovf_prev_q, udf_prev_q;
  logic [1:0] evt;
  logic [1:0] evt_q;
  logic [1:0] isr_q, isr_d;
  logic [1:0] ier_q, ier_d;
  logic [7:0] ovf_cnt_q, ovf_cnt_d;
  logic [7:0] udf_cnt_q, udf_cnt_d;
  logic       mode_q, mode_d;
  logic       irq_d;

  logic access, wr_en, rd_en, addr_valid;
  logic [DATA_WIDTH-1:0] rdata;

  assign evt = {tmr_udf & ~udf_prev_q, tmr_ovf & ~ovf_prev_q};

  // A reset cycle aborts any transfer in flight.
  assign access     = apb.psel & apb.penable & ~preset;
  assign wr_en      = access & apb.pwrite;
  assign rd_en      = access & ~apb.pwrite;
  assign addr_valid = (apb.paddr <= AddrCtrl);

  always_comb begin
    isr_d     = isr_q;
    ier_d     = ier_q;
    ovf_cnt_d = ovf_cnt_q;
    udf_cnt_d = udf_cnt_q;
    mode_d    = mode_q;

    if (wr_en && apb.paddr == AddrIsr) isr_d = isr_q & ~apb.pwdata[1:0];
    isr_d = isr_d | evt;  // set beats a same-cycle clear

    if (wr_en && apb.paddr == AddrIer)  ier_d  = apb.pwdata[1:0];
    if (wr_en && apb.paddr == AddrCtrl) mode_d = apb.pwdata[0];

    // Write-to-clear takes the coincident event into account: result is 1, not 0.
    if (wr_en && apb.paddr == AddrOcnt) ovf_cnt_d = {7'd0, evt[0]};
    else if (evt[0] && ovf_cnt_q != 8'hFF) ovf_cnt_d = ovf_cnt_q + 8'd1;

    if (wr_en && apb.paddr == AddrUcnt) udf_cnt_d = {7'd0, evt[1]};
    else if (evt[1] && udf_cnt_q != 8'hFF) udf_cnt_d = udf_cnt_q + 8'd1;

    // Pulse mode uses the registered events so both modes share the same 2-edge latency.
    irq_d = mode_q ? |(evt_q & ier_q) : |(isr_q & ier_q);
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      ovf_prev_q <= 1'b0;
      udf_prev_q <= 1'b0;
      evt_q      <= 2'b00;
      isr_q      <= 2'b00;
      ier_q      <= 2'b00;
      ovf_cnt_q  <= 8'h00;
      udf_cnt_q  <= 8'h00;
      mode_q     <= 1'b0;
      irq        <= 1'b0;
    end else begin
      ovf_prev_q <= tmr_ovf;
      udf_prev_q <= tmr_udf;
      evt_q      <= evt;
      isr_q      <= isr_d;
      ier_q      <= ier_d;
      ovf_cnt_q  <= ovf_cnt_d;
      udf_cnt_q  <= udf_cnt_d;
      mode_q     <= mode_d;
      irq        <= irq_d;
    end
  end

  always_comb begin
    rdata = '0;
    if (rd_en) begin
      case (apb.paddr)
        AddrIsr:  rdata = DATA_WIDTH'(isr_q);
        AddrIer:  rdata = DATA_WIDTH'(ier_q);
        AddrOcnt: rdata = DATA_WIDTH'(ovf_cnt_q);
        AddrUcnt: rdata = DATA_WIDTH'(udf_cnt_q);
        AddrCtrl: rdata = DATA_WIDTH'(mode_q);
        default:  rdata = '0;
      endcase
    end
  end

  assign apb.prdata  = rdata;
  assign apb.pready  = 1'b1;
  assign apb.pslverr = access & ~addr_valid;

endmodule

// File: tb/tb_tmr_irq_ctrl.sv
module tb_tmr_irq_ctrl;
  logic pclk = 1'b0;
  logic preset;
  logic tmr_ovf, tmr_udf;
  logic irq;
  int   passed = 0;
  int   total  = 0;

  tmr_irq_ctrl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) apb ();

  tmr_irq_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) dut (
    .pclk    (pclk),
    .preset  (preset),
    .apb     (apb),
    .tmr_ovf (tmr_ovf),
    .tmr_udf (tmr_udf),
    .irq     (irq)
  );

  always #5 pclk = ~pclk;

  // Inputs change on the falling edge; outputs are sampled 1 time unit after it.
  task automatic apb_write(input logic [2:0] addr, input logic [7:0] data,
                           input bit set_ovf, input bit set_udf, output logic err);
    @(negedge pclk);
    apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b1;
    apb.paddr = addr; apb.pwdata = data;
    @(negedge pclk);
    apb.penable = 1'b1;
    if (set_ovf) tmr_ovf = 1'b1;
    if (set_udf) tmr_udf = 1'b1;
    #1 err = apb.pslverr;
    @(negedge pclk);
    apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [2:0] addr, output logic [7:0] data, output logic err);
    @(negedge pclk);
    apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b0; apb.paddr = addr;
    @(negedge pclk);
    apb.penable = 1'b1;
    #1 data = apb.prdata; err = apb.pslverr;
    @(negedge pclk);
    apb.psel = 1'b0; apb.penable = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] d; logic e;
    preset = 1'b1;
    repeat (3) @(negedge pclk);
    #1;
    total++; if (apb.pready !== 1'b1) $display("FAIL reset_pready: got %b want 1", apb.pready); else passed++;
    total++; if (irq !== 1'b0) $display("FAIL reset_irq: got %b want 0", irq); else passed++;
    preset = 1'b0;
    for (int a = 0; a < 5; a++) begin
      apb_read(3'(a), d, e);
      total++; if (d !== 8'h00 || e !== 1'b0)
        $display("FAIL reset_read[%0d]: got %h err %b want 00 err 0", a, d, e); else passed++;
    end
    total++; if (irq !== 1'b0) $display("FAIL reset_irq_after: got %b want 0", irq); else passed++;
  endtask

  task automatic test_level();
    logic [7:0] d; logic e;
    apb_write(3'h1, 8'h01, 0, 0, e);
    apb_write(3'h4, 8'h00, 0, 0, e);
    @(negedge pclk); tmr_ovf = 1'b1;       // edge k follows
    @(negedge pclk); #1;
    total++; if (irq !== 1'b0) $display("FAIL level_irq_k: got %b want 0", irq); else passed++;
    @(negedge pclk); #1;
    total++; if (irq !== 1'b1) $display("FAIL level_irq_k1: got %b want 1", irq); else passed++;
    repeat (5) @(negedge pclk); #1;
    total++; if (irq !== 1'b1) $display("FAIL level_irq_hold: got %b want 1", irq); else passed++;
    apb_read(3'h0, d, e);
    total++; if (d !== 8'h01) $display("FAIL level_isr: got %h want 01", d); else passed++;
    apb_read(3'h2, d, e);
    total++; if (d !== 8'h01) $display("FAIL level_ovf_cnt: got %h want 01", d); else passed++;
    apb_write(3'h0, 8'h01, 0, 0, e);       // W1C at edge m; now one cycle after m
    #1;
    total++; if (irq !== 1'b1) $display("FAIL level_irq_m: got %b want 1", irq); else passed++;
    @(negedge pclk); #1;
    total++; if (irq !== 1'b0) $display("FAIL level_irq_m1: got %b want 0", irq); else passed++;
    tmr_ovf = 1'b0;
    apb_read(3'h0, d, e);
    total++; if (d !== 8'h00) $display("FAIL level_isr_cleared: got %h want 00", d); else passed++;
  endtask

  task automatic test_pulse();
    logic [7:0] d; logic e;
    int highs, rises; logic prev;
    apb_write(3'h4, 8'h01, 0, 0, e);
    apb_write(3'h1, 8'h03, 0, 0, e);
    apb_write(3'h2, 8'h00, 0, 0, e);
    apb_write(3'h3, 8'h00, 0, 0, e);
    highs = 0; rises = 0; prev = 1'b0;
    for (int i = 0; i < 24; i++) begin
      @(negedge pclk);
      tmr_ovf = (i == 0 || i == 8 || i == 16);
      tmr_udf = (i == 4 || i == 12);
      #1;
      if (irq === 1'b1) highs++;
      if (irq === 1'b1 && prev !== 1'b1) rises++;
      prev = irq;
    end
    total++; if (highs !== 5) $display("FAIL pulse_high_cycles: got %0d want 5", highs); else passed++;
    total++; if (rises !== 5) $display("FAIL pulse_count: got %0d want 5", rises); else passed++;
    apb_read(3'h2, d, e);
    total++; if (d !== 8'h03) $display("FAIL pulse_ovf_cnt: got %h want 03", d); else passed++;
    apb_read(3'h3, d, e);
    total++; if (d !== 8'h02) $display("FAIL pulse_udf_cnt: got %h want 02", d); else passed++;
    apb_read(3'h0, d, e);
    total++; if (d !== 8'h03) $display("FAIL pulse_isr: got %h want 03", d); else passed++;
  endtask

  task automatic test_saturate();
    logic [7:0] d; logic e;
    for (int i = 0; i < 300; i++) begin
      @(negedge pclk); tmr_udf = 1'b1;
      @(negedge pclk); tmr_udf = 1'b0;
    end
    apb_read(3'h3, d, e);
    total++; if (d !== 8'hFF) $display("FAIL sat_udf_cnt: got %h want ff", d); else passed++;
    apb_write(3'h3, 8'h00, 0, 1, e);       // clear coincides with a UDF event
    tmr_udf = 1'b0;
    apb_read(3'h3, d, e);
    total++; if (d !== 8'h01) $display("FAIL sat_clear_evt: got %h want 01", d); else passed++;
  endtask

  task automatic test_w1c_collision();
    logic [7:0] d; logic e;
    apb_write(3'h0, 8'h03, 0, 0, e);
    apb_read(3'h0, d, e);
    total++; if (d !== 8'h00) $display("FAIL w1c_clear: got %h want 00", d); else passed++;
    apb_write(3'h0, 8'h01, 1, 0, e);       // clear bit0 while OVF event arrives
    tmr_ovf = 1'b0;
    apb_read(3'h0, d, e);
    total++; if (d !== 8'h01) $display("FAIL w1c_set_wins: got %h want 01", d); else passed++;
  endtask

  task automatic test_invalid();
    logic [7:0] d; logic e;
    logic [7:0] exp_regs [5];
    exp_regs = '{8'h01, 8'h03, 8'h04, 8'h01, 8'h01};
    @(negedge pclk);
    apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b1;
    apb.paddr = 3'h6; apb.pwdata = 8'hFF;
    #1;
    total++; if (apb.pslverr !== 1'b0) $display("FAIL inv_err_setup: got %b want 0", apb.pslverr); else passed++;
    @(negedge pclk); apb.penable = 1'b1; #1;
    total++; if (apb.pslverr !== 1'b1) $display("FAIL inv_err_access: got %b want 1", apb.pslverr); else passed++;
    @(negedge pclk); apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0; #1;
    total++; if (apb.pslverr !== 1'b0) $display("FAIL inv_err_idle: got %b want 0", apb.pslverr); else passed++;
    apb_read(3'h6, d, e);
    total++; if (d !== 8'h00 || e !== 1'b1)
      $display("FAIL inv_read: got %h err %b want 00 err 1", d, e); else passed++;
    for (int a = 0; a < 5; a++) begin
      apb_read(3'(a), d, e);
      total++; if (d !== exp_regs[a])
        $display("FAIL inv_unchanged[%0d]: got %h want %h", a, d, exp_regs[a]); else passed++;
    end
  endtask

  task automatic test_reset_held();
    logic [7:0] d; logic e;
    tmr_ovf = 1'b1;
    @(negedge pclk);
    apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b1; apb.paddr = 3'h1; apb.pwdata = 8'h03;
    @(negedge pclk);
    apb.penable = 1'b1; preset = 1'b1;    // reset aborts this IER write
    @(negedge pclk);
    apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
    repeat (2) @(negedge pclk);
    #1;
    total++; if (irq !== 1'b0) $display("FAIL rst_irq: got %b want 0", irq); else passed++;
    preset = 1'b0;
    apb_read(3'h1, d, e);
    total++; if (d !== 8'h00) $display("FAIL rst_ier_aborted: got %h want 00", d); else passed++;
    apb_read(3'h2, d, e);
    total++; if (d !== 8'h01) $display("FAIL rst_ovf_cnt: got %h want 01", d); else passed++;
    apb_read(3'h0, d, e);
    total++; if (d !== 8'h01) $display("FAIL rst_isr: got %h want 01", d); else passed++;
    tmr_ovf = 1'b0;
  endtask

  initial begin
    preset = 1'b1; tmr_ovf = 1'b0; tmr_udf = 1'b0;
    apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0; apb.paddr = '0; apb.pwdata = '0;
    test_reset();
    test_level();
    test_pulse();
    test_saturate();
    test_w1c_collision();
    test_invalid();
    test_reset_held();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d of %0d passed", passed, total);
    $fatal(1);
  end
endmodule
